alu_share_arbiter: RTL and testbench

- Shares the single registered R-type ALU between two independent requesters, port 0 and port 1; typical pairing is the execute stage and the debug/test injector.
- Accepts operations over valid/ready, arbitrates round-robin and issues one operation at a time as a one-cycle opcode pulse.
- Captures the ALU result or error and returns it, tagged with the requester id, over a valid/ready response channel.
- Provides a timeout so an unaccepted opcode cannot hang the core.

---
 rtl/alu_share_arbiter_if.sv | 37 +++
 rtl/alu_share_arbiter.sv | 92 +++++++++
 tb/tb_alu_share_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, ALU and response bundle for the shared ALU arbiter.
interface alu_share_arbiter_if;
    logic        req0_valid, req0_ready;
    logic [6:0]  req0_opcode, req0_funct7;
    logic [2:0]  req0_funct3;
    logic [31:0] req0_rs1, req0_rs2;
    logic        req1_valid, req1_ready;
    logic [6:0]  req1_opcode, req1_funct7;
    logic [2:0]  req1_funct3;
    logic [31:0] req1_rs1, req1_rs2;
    logic [6:0]  alu_opcode, alu_funct7;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_rs1, alu_rs2, alu_result;
    logic        alu_active, alu_decoding_error;
    logic        resp_valid, resp_ready, resp_id, resp_error, resp_timeout, busy;
    logic [31:0] resp_result;

    modport master(
        input  req0_valid, req0_opcode, req0_funct3, req0_funct7, req0_rs1, req0_rs2,
        input  req1_valid, req1_opcode, req1_funct3, req1_funct7, req1_rs1, req1_rs2,
        output req0_ready, req1_ready,
        output alu_opcode, alu_funct3, alu_funct7, alu_rs1, alu_rs2,
        input  alu_active, alu_decoding_error, alu_result,
        output resp_valid, resp_id, resp_result, resp_error, resp_timeout, busy,
        input  resp_ready
    );

    modport slave(
        output req0_valid, req0_opcode, req0_funct3, req0_funct7, req0_rs1, req0_rs2,
        output req1_valid, req1_opcode, req1_funct3, req1_funct7, req1_rs1, req1_rs2,
        input  req0_ready, req1_ready,
        input  alu_opcode, alu_funct3, alu_funct7, alu_rs1, alu_rs2,
        output alu_active, alu_decoding_error, alu_result,
        input  resp_valid, resp_id, resp_result, resp_error, resp_timeout, busy,
        output resp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one registered R-type ALU between two requesters.
module alu_share_arbiter #(
    parameter int         TIMEOUT_CYCLES = 4,
    parameter logic [6:0] RTYPE_OPCODE   = 7'b0110011
) (
    input logic            clk,
    input logic            reset,
    alu_share_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || RTYPE_OPCODE[1:0] != 2'b11) begin : g_bad_param
        $error("alu_share_arbiter: illegal parameter");
    end

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic        prio, id_q, gnt, any_req, tmo;
    logic [6:0]  op_q, f7_q;
    logic [2:0]  f3_q;
    logic [31:0] rs1_q, rs2_q, res_q;
    logic        err_q, tmo_q;

    // Timeout fires on the WAIT cycle whose incremented count reaches TIMEOUT_CYCLES-1.
    always_comb begin
        gnt = bus.req1_valid && (!bus.req0_valid || prio);
        any_req = bus.req0_valid || bus.req1_valid;
        tmo = ({1'b0, cnt} + 9'd2) >= 9'(TIMEOUT_CYCLES);
        state_n = state;
        case (state)
            IDLE:    state_n = any_req ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = (bus.alu_active || tmo) ? RESP : WAIT;
            default: state_n = bus.resp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            prio <= 1'b0;
            cnt <= 8'd0;
            id_q <= 1'b0;
            op_q <= 7'd0;
            f3_q <= 3'd0;
            f7_q <= 7'd0;
            rs1_q <= 32'd0;
            rs2_q <= 32'd0;
            res_q <= 32'd0;
            err_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && any_req) begin
                id_q <= gnt;
                op_q <= gnt ? bus.req1_opcode : bus.req0_opcode;
                f3_q <= gnt ? bus.req1_funct3 : bus.req0_funct3;
                f7_q <= gnt ? bus.req1_funct7 : bus.req0_funct7;
                rs1_q <= gnt ? bus.req1_rs1 : bus.req0_rs1;
                rs2_q <= gnt ? bus.req1_rs2 : bus.req0_rs2;
            end
            if (state == ISSUE) cnt <= 8'd0;
            if (state == WAIT) begin
                cnt <= cnt + 8'd1;
                if (bus.alu_active) begin
                    res_q <= bus.alu_result;
                    err_q <= bus.alu_decoding_error;
                    tmo_q <= 1'b0;
                end else if (tmo) begin
                    res_q <= 32'd0;
                    err_q <= 1'b1;
                    tmo_q <= 1'b1;
                end
            end
            if (state == RESP && bus.resp_ready) prio <= ~id_q;
        end
    end

    assign bus.req0_ready   = state == IDLE && bus.req0_valid && !gnt;
    assign bus.req1_ready   = state == IDLE && gnt;
    assign bus.alu_opcode   = state == ISSUE ? op_q : 7'd0;
    assign bus.alu_funct3   = f3_q;
    assign bus.alu_funct7   = f7_q;
    assign bus.alu_rs1      = rs1_q;
    assign bus.alu_rs2      = rs2_q;
    assign bus.resp_valid   = state == RESP;
    assign bus.resp_id      = id_q;
    assign bus.resp_result  = res_q;
    assign bus.resp_error   = err_q;
    assign bus.resp_timeout = tmo_q;
    assign bus.busy         = state != IDLE;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios against a registered adder-style ALU model.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_mode = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_share_arbiter_if bus();
    alu_share_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // ALU model: only R-type opcodes make it active one cycle after ISSUE; result is rs1+rs2.
    always @(posedge clk) begin
        bus.alu_active <= bus.alu_opcode == 7'b0110011;
        bus.alu_result <= bus.alu_rs1 + bus.alu_rs2;
        bus.alu_decoding_error <= err_mode && bus.alu_opcode == 7'b0110011;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid = v; bus.req0_opcode = op; bus.req0_funct3 = 3'd0; bus.req0_funct7 = 7'd0;
        bus.req0_rs1 = a; bus.req0_rs2 = b;
    endtask

    task automatic set_req1(input logic v, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid = v; bus.req1_opcode = op; bus.req1_funct3 = 3'd0; bus.req1_funct7 = 7'd0;
        bus.req1_rs1 = a; bus.req1_rs2 = b;
    endtask

    task automatic test_reset();
        set_req0(1'b0, 7'd0, 32'd0, 32'd0);
        set_req1(1'b0, 7'd0, 32'd0, 32'd0);
        bus.resp_ready = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        n_chk++; if ({bus.resp_id, bus.resp_error, bus.resp_timeout, bus.resp_result} !== 35'd0) begin n_fail++; $display("FAIL reset_resp: got %h want 0", {bus.resp_id, bus.resp_error, bus.resp_timeout, bus.resp_result}); end
        n_chk++; if ({bus.alu_opcode, bus.alu_rs1, bus.alu_rs2} !== 71'd0) begin n_fail++; $display("FAIL reset_alu: got %h want 0", {bus.alu_opcode, bus.alu_rs1, bus.alu_rs2}); end
    endtask

    task automatic test_basic();
        set_req0(1'b1, 7'b0110011, 32'd3, 32'd4);
        #1;
        n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL basic_ready: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        step();
        n_chk++; if (bus.alu_opcode !== 7'b0110011) begin n_fail++; $display("FAIL basic_issue_opcode: got %b want 0110011", bus.alu_opcode); end
        n_chk++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_issue: got %b want 0", bus.req0_ready); end
        set_req0(1'b0, 7'd0, 32'd0, 32'd0);
        step();
        n_chk++; if ({bus.alu_opcode, bus.resp_valid} !== 8'd0) begin n_fail++; $display("FAIL basic_wait: got %h want 0", {bus.alu_opcode, bus.resp_valid}); end
        n_chk++; if ({bus.alu_rs1, bus.alu_rs2} !== {32'd3, 32'd4}) begin n_fail++; $display("FAIL basic_operands_hold: got %h want %h", {bus.alu_rs1, bus.alu_rs2}, {32'd3, 32'd4}); end
        step();
        n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_timeout} !== 4'b1000) begin n_fail++; $display("FAIL basic_resp_flags: got %b want 1000", {bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_timeout}); end
        n_chk++; if (bus.resp_result !== 32'h7) begin n_fail++; $display("FAIL basic_resp_result: got %h want 7", bus.resp_result); end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        n_chk++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL basic_after_handshake: got %b want 00", {bus.resp_valid, bus.busy}); end
    endtask

    task automatic test_decode_error();
        err_mode = 1'b1;
        set_req1(1'b1, 7'b0110011, 32'd1, 32'd2);
        #1;
        n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL decerr_ready: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        step();
        set_req1(1'b0, 7'd0, 32'd0, 32'd0);
        step(); step();
        n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_timeout} !== 4'b1110) begin n_fail++; $display("FAIL decerr_flags: got %b want 1110", {bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_timeout}); end
        n_chk++; if (bus.resp_result !== 32'd3) begin n_fail++; $display("FAIL decerr_result: got %h want 3", bus.resp_result); end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        err_mode = 1'b0;
    endtask

    task automatic test_timeout();
        set_req1(1'b1, 7'b0010011, 32'd9, 32'd9);
        #1;
        n_chk++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_ready: got %b want 1", bus.req1_ready); end
        step();
        n_chk++; if (bus.alu_opcode !== 7'b0010011) begin n_fail++; $display("FAIL tmo_issue_opcode: got %b want 0010011", bus.alu_opcode); end
        set_req1(1'b0, 7'd0, 32'd0, 32'd0);
        step(); step(); step();
        n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", bus.resp_valid); end
        step();
        n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_timeout} !== 4'b1111) begin n_fail++; $display("FAIL tmo_flags: got %b want 1111", {bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_timeout}); end
        n_chk++; if (bus.resp_result !== 32'd0) begin n_fail++; $display("FAIL tmo_result: got %h want 0", bus.resp_result); end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.resp_ready = 1'b1;
        set_req0(1'b1, 7'b0110011, 32'd10, 32'd20);
        set_req1(1'b1, 7'b0110011, 32'd100, 32'd5);
        #1;
        n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_first_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        step(); step(); step();
        n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_result} !== {2'b10, 32'd30}) begin n_fail++; $display("FAIL b2b_resp0: got %h want %h", {bus.resp_valid, bus.resp_id, bus.resp_result}, {2'b10, 32'd30}); end
        step();
        n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_second_grant: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        step(); step(); step();
        n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_result} !== {2'b11, 32'd105}) begin n_fail++; $display("FAIL b2b_resp1: got %h want %h", {bus.resp_valid, bus.resp_id, bus.resp_result}, {2'b11, 32'd105}); end
        step();
        n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_third_grant: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        set_req0(1'b0, 7'd0, 32'd0, 32'd0);
        set_req1(1'b0, 7'd0, 32'd0, 32'd0);
        bus.resp_ready = 1'b0;
        step();
    endtask

    task automatic test_resp_hold();
        set_req0(1'b1, 7'b0110011, 32'd5, 32'd6);
        step();
        set_req0(1'b0, 7'd0, 32'd0, 32'd0);
        step(); step();
        set_req0(1'b1, 7'b0110011, 32'd7, 32'd8);
        set_req1(1'b1, 7'b0110011, 32'd1, 32'd1);
        for (int i = 0; i < 10; i++) begin
            n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_timeout, bus.resp_result, bus.req0_ready, bus.req1_ready} !== {4'b1000, 32'd11, 2'b00}) begin n_fail++; $display("FAIL hold_cycle%0d: got %h want %h", i, {bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_timeout, bus.resp_result, bus.req0_ready, bus.req1_ready}, {4'b1000, 32'd11, 2'b00}); end
            step();
        end
        set_req1(1'b0, 7'd0, 32'd0, 32'd0);
        bus.resp_ready = 1'b1;
        #1;
        n_chk++; if ({bus.resp_valid, bus.req0_ready} !== 2'b10) begin n_fail++; $display("FAIL hold_handshake_cycle: got %b want 10", {bus.resp_valid, bus.req0_ready}); end
        step();
        bus.resp_ready = 1'b0;
        n_chk++; if ({bus.resp_valid, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL hold_accept_after: got %b want 01", {bus.resp_valid, bus.req0_ready}); end
        step();
        set_req0(1'b0, 7'd0, 32'd0, 32'd0);
        step(); step();
        n_chk++; if ({bus.resp_valid, bus.resp_id, bus.resp_result} !== {2'b10, 32'd15}) begin n_fail++; $display("FAIL hold_queued_resp: got %h want %h", {bus.resp_valid, bus.resp_id, bus.resp_result}, {2'b10, 32'd15}); end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_req1(1'b1, 7'b0110011, 32'd2, 32'd2);
        step();
        set_req1(1'b0, 7'd0, 32'd0, 32'd0);
        step();
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_wait: got %b want 1", bus.busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_chk++; if ({bus.busy, bus.resp_valid, bus.alu_opcode} !== 9'd0) begin n_fail++; $display("FAIL rstmid_cleared: got %h want 0", {bus.busy, bus.resp_valid, bus.alu_opcode}); end
        set_req0(1'b1, 7'b0110011, 32'd0, 32'd0);
        set_req1(1'b1, 7'b0110011, 32'd0, 32'd0);
        #1;
        n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rstmid_prio: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        set_req0(1'b0, 7'd0, 32'd0, 32'd0);
        set_req1(1'b0, 7'd0, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            n_chk++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_resp%0d: got %b want 00", i, {bus.resp_valid, bus.busy}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decode_error();
        test_timeout();
        test_back_to_back();
        test_resp_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
